brushless_ctrl: RTL

BRUSHLESS_CTRL -- requirements
Module: brushless_ctrl

---
 rtl/brushless_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/brushless_ctrl.sv
// Six-step brushless motor commutation controller with Hall synchronizers, duty ramp, brake and Hall-fault states.
// Outputs are registered; RUN updates land on the edge that samples PWM_synch high, state changes on any edge.
module brushless_ctrl #(
    parameter logic [10:0] RAMP_STEP  = 11'd8,
    parameter logic [10:0] BRAKE_DUTY = 11'h600,
    parameter logic [1:0]  ERR_LIMIT  = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        brake_n,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic [10:0] drv_mag,
    input  logic        PWM_synch,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        hall_err
);

    typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} state_t;

    localparam logic [5:0] SEL_OFF   = 6'b00_00_00;
    localparam logic [5:0] SEL_BRAKE = 6'b11_11_11;

    state_t      state, state_nxt;
    logic [2:0]  hall_s1, hall_s2;
    logic [1:0]  err_cnt, err_cnt_nxt;
    logic [2:0]  err_inc;
    logic [10:0] duty_nxt;
    logic [5:0]  sel, sel_nxt;
    logic        hall_valid;

    function automatic logic [5:0] commutate(input logic [2:0] h);
        case (h)
            3'b101:  commutate = 6'b10_01_00;
            3'b100:  commutate = 6'b10_00_01;
            3'b110:  commutate = 6'b00_10_01;
            3'b010:  commutate = 6'b01_10_00;
            3'b011:  commutate = 6'b01_00_10;
            3'b001:  commutate = 6'b00_01_10;
            default: commutate = SEL_OFF;
        endcase
    endfunction

    // Compare the remaining gap against the step so the sum/difference can never wrap.
    function automatic logic [10:0] ramp(input logic [10:0] cur, input logic [10:0] tgt);
        logic [11:0] gap;
        gap = 12'd0;
        ramp = cur;
        if (cur < tgt) begin
            gap  = {1'b0, tgt} - {1'b0, cur};
            ramp = (gap <= {1'b0, RAMP_STEP}) ? tgt : cur + RAMP_STEP;
        end else if (cur > tgt) begin
            gap  = {1'b0, cur} - {1'b0, tgt};
            ramp = (gap <= {1'b0, RAMP_STEP}) ? tgt : cur - RAMP_STEP;
        end
    endfunction

    assign hall_valid = (hall_s2 != 3'b000) && (hall_s2 != 3'b111);
    assign err_inc    = {1'b0, err_cnt} + 3'd1;
    assign {selGrn, selYlw, selBlu} = sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hall_s1  <= 3'b000;
            hall_s2  <= 3'b000;
            err_cnt  <= 2'd0;
            duty     <= 11'd0;
            sel      <= SEL_OFF;
            hall_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            hall_s1  <= {hallGrn, hallYlw, hallBlu};
            hall_s2  <= hall_s1;
            err_cnt  <= err_cnt_nxt;
            duty     <= duty_nxt;
            sel      <= sel_nxt;
            hall_err <= (state_nxt == FAULT);
        end
    end

    always_comb begin
        state_nxt   = state;
        duty_nxt    = duty;
        sel_nxt     = sel;
        err_cnt_nxt = err_cnt;
        case (state)
            IDLE: begin
                duty_nxt    = 11'd0;
                sel_nxt     = SEL_OFF;
                err_cnt_nxt = 2'd0;
                if (!brake_n) begin
                    state_nxt = BRAKE;
                    duty_nxt  = BRAKE_DUTY;
                    sel_nxt   = SEL_BRAKE;
                end else if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Brake wins over a coincident PWM_synch; no ramp step is applied then.
                if (!brake_n) begin
                    state_nxt   = BRAKE;
                    duty_nxt    = BRAKE_DUTY;
                    sel_nxt     = SEL_BRAKE;
                    err_cnt_nxt = 2'd0;
                end else if (!en) begin
                    state_nxt   = IDLE;
                    duty_nxt    = 11'd0;
                    sel_nxt     = SEL_OFF;
                    err_cnt_nxt = 2'd0;
                end else if (PWM_synch) begin
                    duty_nxt = ramp(duty, drv_mag);
                    if (hall_valid) begin
                        sel_nxt     = commutate(hall_s2);
                        err_cnt_nxt = 2'd0;
                    end else begin
                        sel_nxt     = SEL_OFF;
                        err_cnt_nxt = err_inc[1:0];
                        if (err_inc >= {1'b0, ERR_LIMIT}) begin
                            state_nxt = FAULT;
                            duty_nxt  = 11'd0;
                        end
                    end
                end
            end
            BRAKE: begin
                duty_nxt = BRAKE_DUTY;
                sel_nxt  = SEL_BRAKE;
                if (brake_n) begin
                    state_nxt = IDLE;
                    duty_nxt  = 11'd0;
                    sel_nxt   = SEL_OFF;
                end
            end
            FAULT: begin
                duty_nxt = 11'd0;
                sel_nxt  = SEL_OFF;
            end
            default: begin
                state_nxt = IDLE;
                duty_nxt  = 11'd0;
                sel_nxt   = SEL_OFF;
            end
        endcase
    end

endmodule
